// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: lamp-stage state encoding and one-hot lamp constants.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_DEADTIME = 2'd1,
        ST_ON       = 2'd2,
        ST_FAULT    = 2'd3
    } lamp_state_e;

    localparam logic [2:0] LAMP_NONE   = 3'b000;
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // True when exactly one of {red, yellow, green} is requested.
    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v == LAMP_RED) || (v == LAMP_YELLOW) || (v == LAMP_GREEN);
    endfunction

endpackage

// File: rtl/lamp_pwm.sv
// Free-running PWM counter and duty comparator; all-ones duty forces the lamp fully on.
module lamp_pwm #(
    parameter int unsigned PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PWM_WIDTH-1:0] duty,
    output logic                 pwm_on_c
);

    logic [PWM_WIDTH-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
        end
    end

    assign pwm_on_c = (duty == {PWM_WIDTH{1'b1}}) || (pwm_cnt < duty);

endmodule

// File: rtl/lamp_driver.sv
// Lamp output stage: break-before-make dead time, PWM dimming, one-hot integrity
// checking and a latched flashing-yellow fault mode.
module lamp_driver
    import traffic_pkg::*;
#(
    parameter int unsigned DEADTIME_CYCLES   = 4,
    parameter int unsigned FAULT_CYCLES      = 16,
    parameter int unsigned FLASH_HALF_PERIOD = 2,
    parameter int unsigned PWM_WIDTH         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 red_in,
    input  logic                 yellow_in,
    input  logic                 green_in,
    input  logic [PWM_WIDTH-1:0] duty,
    input  logic                 fault_clear,
    output logic                 lamp_red,
    output logic                 lamp_yellow,
    output logic                 lamp_green,
    output logic                 fault
);

    localparam int unsigned DT_W    = $clog2(DEADTIME_CYCLES + 1);
    localparam int unsigned INV_W   = $clog2(FAULT_CYCLES + 1);
    localparam int unsigned FLASH_W = $clog2(FLASH_HALF_PERIOD + 1);

    lamp_state_e        state;
    logic [2:0]         sel;
    logic [2:0]         target;
    logic [2:0]         lamps;
    logic [DT_W-1:0]    dt_cnt;
    logic [INV_W-1:0]   inv_cnt;
    logic [FLASH_W-1:0] flash_cnt;

    logic [2:0]         in_c;
    logic               in_valid_c;
    logic [INV_W-1:0]   inv_cnt_nxt_c;
    logic               fault_trip_c;
    logic               pwm_on_c;

    lamp_pwm #(
        .PWM_WIDTH(PWM_WIDTH)
    ) u_pwm (
        .clk      (clk),
        .reset    (reset),
        .duty     (duty),
        .pwm_on_c (pwm_on_c)
    );

    assign in_c       = {red_in, yellow_in, green_in};
    assign in_valid_c = is_one_hot3(in_c);

    // Consecutive-invalid counter, saturating at the fault threshold.
    always_comb begin
        inv_cnt_nxt_c = '0;
        if (!in_valid_c) begin
            if (inv_cnt == INV_W'(FAULT_CYCLES)) begin
                inv_cnt_nxt_c = inv_cnt;
            end else begin
                inv_cnt_nxt_c = inv_cnt + INV_W'(1);
            end
        end
    end

    assign fault_trip_c = (state != ST_FAULT) && (inv_cnt_nxt_c == INV_W'(FAULT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_OFF;
            sel       <= LAMP_NONE;
            target    <= LAMP_NONE;
            lamps     <= LAMP_NONE;
            dt_cnt    <= '0;
            inv_cnt   <= '0;
            flash_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            inv_cnt <= inv_cnt_nxt_c;
            if (fault_trip_c) begin
                // Fault overrides everything; yellow starts lit.
                state     <= ST_FAULT;
                fault     <= 1'b1;
                lamps     <= LAMP_YELLOW;
                flash_cnt <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        lamps <= LAMP_NONE;
                        if (in_valid_c) begin
                            state  <= ST_DEADTIME;
                            target <= in_c;
                            dt_cnt <= '0;
                        end
                    end
                    ST_DEADTIME: begin
                        lamps <= LAMP_NONE;
                        if (in_valid_c && (in_c != target)) begin
                            target <= in_c;
                            dt_cnt <= '0;
                        end else if (in_valid_c) begin
                            if (dt_cnt == DT_W'(DEADTIME_CYCLES - 1)) begin
                                state  <= ST_ON;
                                sel    <= target;
                                lamps  <= target & {3{pwm_on_c}};
                                dt_cnt <= '0;
                            end else begin
                                dt_cnt <= dt_cnt + DT_W'(1);
                            end
                        end
                    end
                    ST_ON: begin
                        if (in_valid_c && (in_c != sel)) begin
                            state  <= ST_DEADTIME;
                            target <= in_c;
                            dt_cnt <= '0;
                            lamps  <= LAMP_NONE;
                        end else begin
                            lamps <= sel & {3{pwm_on_c}};
                        end
                    end
                    ST_FAULT: begin
                        if (fault_clear && in_valid_c) begin
                            state  <= ST_DEADTIME;
                            target <= in_c;
                            dt_cnt <= '0;
                            fault  <= 1'b0;
                            lamps  <= LAMP_NONE;
                        end else if (tick) begin
                            if (flash_cnt == FLASH_W'(FLASH_HALF_PERIOD - 1)) begin
                                flash_cnt <= '0;
                                lamps     <= lamps ^ LAMP_YELLOW;
                            end else begin
                                flash_cnt <= flash_cnt + FLASH_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_OFF;
                        lamps <= LAMP_NONE;
                    end
                endcase
            end
        end
    end

    assign {lamp_red, lamp_yellow, lamp_green} = lamps;

endmodule

// File: tb/tb_lamp_driver.sv
// Bench for lamp_driver: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the lamp rules.
module tb_lamp_driver;
    import traffic_pkg::*;

    localparam int D   = 4;
    localparam int FC  = 16;
    localparam int FHP = 2;
    localparam int PW  = 8;

    logic          clk;
    logic          reset;
    logic          tick;
    logic          red_in, yellow_in, green_in;
    logic [PW-1:0] duty;
    logic          fault_clear;
    logic          lamp_red, lamp_yellow, lamp_green;
    logic          fault;

    int n_checks = 0;
    int n_err    = 0;
    int tick_div = 0;

    lamp_driver #(
        .DEADTIME_CYCLES   (D),
        .FAULT_CYCLES      (FC),
        .FLASH_HALF_PERIOD (FHP),
        .PWM_WIDTH         (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .red_in      (red_in),
        .yellow_in   (yellow_in),
        .green_in    (green_in),
        .duty        (duty),
        .fault_clear (fault_clear),
        .lamp_red    (lamp_red),
        .lamp_yellow (lamp_yellow),
        .lamp_green  (lamp_green),
        .fault       (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slow tick: one pulse every 5 clocks.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div == 4) ? 0 : tick_div + 1;
            tick = (tick_div == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the colour on show, the colour waited for with the number of
    // valid cycles still to wait, the length of the current invalid run and the tick
    // count since the fault began.
    logic [2:0] m_lit, m_pend;
    int         m_wait, m_bad, m_ticks, m_pcnt;
    bit         m_faulted;
    logic [3:0] m_exp;

    task automatic m_reset();
        m_lit = LAMP_NONE; m_pend = LAMP_NONE;
        m_wait = 0; m_bad = 0; m_ticks = 0; m_pcnt = 0;
        m_faulted = 1'b0; m_exp = 4'b0000;
    endtask

    task automatic m_step(input logic [2:0] col, input logic [PW-1:0] d,
                          input logic clr, input logic tk);
        bit inv, bright;
        int phase;
        inv    = ($countones(col) != 1);
        phase  = m_pcnt;
        m_pcnt = (m_pcnt + 1) % (1 << PW);
        bright = (d == {PW{1'b1}}) || (phase < int'(d));
        m_bad  = inv ? ((m_bad < FC) ? m_bad + 1 : FC) : 0;
        if (m_faulted) begin
            if (clr && !inv) begin
                m_faulted = 1'b0; m_lit = LAMP_NONE; m_pend = col; m_wait = D;
            end else if (tk) begin
                m_ticks++;
            end
        end else if (m_bad == FC) begin
            m_faulted = 1'b1; m_ticks = 0; m_lit = LAMP_NONE; m_pend = LAMP_NONE;
        end else if (m_lit != LAMP_NONE) begin
            if (!inv && col != m_lit) begin
                m_lit = LAMP_NONE; m_pend = col; m_wait = D;
            end
        end else if (!inv) begin
            if (m_pend == LAMP_NONE || col != m_pend) begin
                m_pend = col; m_wait = D;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_lit = m_pend; m_pend = LAMP_NONE;
                end
            end
        end
        if (m_faulted) m_exp = {1'b1, 1'b0, ((m_ticks / FHP) % 2 == 0), 1'b0};
        else           m_exp = {1'b0, m_lit & {3{bright}}};
    endtask

    // Per-cycle compare against the model plus lamp-safety invariants.
    initial begin
        logic [2:0] prev, cur;
        prev = LAMP_NONE;
        m_reset();
        forever begin
            @(posedge clk);
            if (reset) m_reset();
            else m_step({red_in, yellow_in, green_in}, duty, fault_clear, tick);
            #1;
            cur = {lamp_red, lamp_yellow, lamp_green};
            chk("outputs", {fault, cur}, m_exp);
            chk("onehot0", 32'($onehot0(cur)), 1);
            if (!fault)
                chk("adjacent", 32'(!(prev != LAMP_NONE && cur != LAMP_NONE && prev != cur)), 1);
            prev = reset ? LAMP_NONE : cur;
        end
    end

    task automatic set_in(input logic [2:0] col);
        {red_in, yellow_in, green_in} = col;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [2:0] cols    [3] = '{LAMP_RED, LAMP_YELLOW, LAMP_GREEN};
    logic [2:0] bad_pat [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        int cnt, k;
        reset = 1'b1; set_in(LAMP_NONE); duty = 8'hFF; fault_clear = 1'b0;
        cyc(3);
        reset = 1'b0;
        chk("reset_state", {fault, lamp_red, lamp_yellow, lamp_green}, 0);

        // First colour after reset: dark for the dead time, then red at full duty.
        set_in(LAMP_RED);
        cyc(4); chk("red_gap", {lamp_red, lamp_yellow, lamp_green}, LAMP_NONE);
        cyc(1); chk("red_on", {lamp_red, lamp_yellow, lamp_green}, LAMP_RED);
        chk("red_nofault", fault, 0);
        cyc(3);

        // Direct red->green swap.
        set_in(LAMP_GREEN);
        cyc(4); chk("swap_gap", {lamp_red, lamp_yellow, lamp_green}, LAMP_NONE);
        cyc(1); chk("swap_green", {lamp_red, lamp_yellow, lamp_green}, LAMP_GREEN);
        cyc(3);

        // Dead-time restart: toward red, yellow glitch for one cycle, back to red.
        set_in(LAMP_RED);    cyc(2);
        set_in(LAMP_YELLOW); cyc(1);
        set_in(LAMP_RED);
        cyc(4); chk("restart_gap", {lamp_red, lamp_yellow, lamp_green}, LAMP_NONE);
        cyc(1); chk("restart_red", {lamp_red, lamp_yellow, lamp_green}, LAMP_RED);
        cyc(3);

        // PWM brightness over one full counter period.
        duty = 8'h40; cnt = 0;
        for (int i = 0; i < 256; i++) begin cyc(1); cnt += int'(lamp_red); end
        chk("duty_40", cnt, 64);
        duty = 8'h00; cnt = 0;
        for (int i = 0; i < 256; i++) begin cyc(1); cnt += int'(lamp_red); end
        chk("duty_0", cnt, 0);
        duty = 8'hFF; cyc(2);

        // Invalid-input threshold.
        set_in(LAMP_NONE);
        cyc(15);
        chk("inv15_fault", fault, 0);
        chk("inv15_hold", {lamp_red, lamp_yellow, lamp_green}, LAMP_RED);
        cyc(1);
        chk("inv16_fault", fault, 1);
        chk("inv16_yellow", {lamp_red, lamp_yellow, lamp_green}, LAMP_YELLOW);
        cyc(40);

        // Clear with invalid input is ignored; clear with red restarts via dead time.
        fault_clear = 1'b1; cyc(1); fault_clear = 1'b0;
        chk("clear_invalid", fault, 1);
        cyc(3);
        set_in(LAMP_RED); fault_clear = 1'b1; cyc(1); fault_clear = 1'b0;
        chk("clear_fault", fault, 0);
        chk("clear_dark", {lamp_red, lamp_yellow, lamp_green}, LAMP_NONE);
        cyc(3); chk("clear_gap", {lamp_red, lamp_yellow, lamp_green}, LAMP_NONE);
        cyc(1); chk("clear_red", {lamp_red, lamp_yellow, lamp_green}, LAMP_RED);

        // Async reset in the middle of a flash.
        set_in(LAMP_NONE);
        cyc(16); chk("refault", fault, 1);
        cyc(30);
        #2 reset = 1'b1;
        #1 chk("async_reset", {fault, lamp_red, lamp_yellow, lamp_green}, 0);
        cyc(2);
        reset = 1'b0;

        // Randomized traffic.
        for (int s = 0; s < 400; s++) begin
            k = $urandom_range(0, 9);
            if ($urandom_range(0, 5) == 0)
                duty = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            if (k <= 6) begin
                set_in(cols[$urandom_range(0, 2)]);
                cyc($urandom_range(1, 12));
            end else if (k <= 8) begin
                set_in(bad_pat[$urandom_range(0, 4)]);
                cyc($urandom_range(1, 20));
            end else begin
                set_in(3'($urandom_range(0, 7)));
                fault_clear = 1'b1; cyc(1); fault_clear = 1'b0;
                cyc($urandom_range(0, 6));
            end
        end
        cyc(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
